// File: rtl/basic_computer_pkg.sv
// Shared constants for the basic-computer control path: widths, opcodes and timing indices.
package basic_computer_pkg;

  localparam int SC_W = 4;
  localparam int OP_W = 3;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_IOR = 3'd7;

  localparam int T0_IDX  = 0;
  localparam int T1_IDX  = 1;
  localparam int T2_IDX  = 2;
  localparam int T3_IDX  = 3;
  localparam int T4_IDX  = 4;
  localparam int T5_IDX  = 5;
  localparam int T6_IDX  = 6;
  localparam int T7_IDX  = 7;
  localparam int T8_IDX  = 8;
  localparam int T9_IDX  = 9;
  localparam int T10_IDX = 10;
  localparam int T11_IDX = 11;
  localparam int T12_IDX = 12;
  localparam int T13_IDX = 13;
  localparam int T14_IDX = 14;
  localparam int T15_IDX = 15;

endpackage

// File: rtl/onehot_dec.sv
// Purely combinational binary to one-hot decoder.
module onehot_dec #(
  parameter int IN_W = 4
) (
  input  logic [IN_W-1:0]      in_val,
  output logic [(2**IN_W)-1:0] out_onehot
);

  always_comb begin
    out_onehot         = '0;
    out_onehot[in_val] = 1'b1;
  end

endmodule

// File: rtl/timing_sequencer.sv
// Timing-and-control front end: S, SC, R and latched decode, plus fetch/interrupt strobes.
module timing_sequencer
  import basic_computer_pkg::*;
#(
  parameter int SC_W = basic_computer_pkg::SC_W,
  parameter int OP_W = basic_computer_pkg::OP_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  sc_clr,
  input  logic [OP_W-1:0]       ir_op,
  input  logic                  ir_i,
  input  logic                  ien,
  input  logic                  fgi,
  input  logic                  fgo,
  output logic                  running,
  output logic [(2**SC_W)-1:0]  T,
  output logic [(2**OP_W)-1:0]  D,
  output logic                  I,
  output logic                  R,
  output logic                  ar_ld_pc,
  output logic                  ir_ld_mem,
  output logic                  pc_inc,
  output logic                  ar_ld_ir,
  output logic                  ar_clr,
  output logic                  tr_ld_pc,
  output logic                  mem_wr_tr,
  output logic                  pc_clr,
  output logic                  ien_clr,
  output logic                  sc_overrun
);

  localparam logic [SC_W-1:0] SC_MAX = '1;

  logic                 s_q, s_d;
  logic [SC_W-1:0]      sc_q, sc_d;
  logic                 r_q, r_d;
  logic [(2**OP_W)-1:0] d_q, d_d;
  logic                 i_q, i_d;
  logic                 ovr_q, ovr_d;

  logic [(2**SC_W)-1:0] t_raw;
  logic [(2**SC_W)-1:0] t_act;
  logic [(2**OP_W)-1:0] op_onehot;
  logic                 fetch_decode_end;

  onehot_dec #(.IN_W(SC_W)) u_t_dec (.in_val(sc_q),  .out_onehot(t_raw));
  onehot_dec #(.IN_W(OP_W)) u_d_dec (.in_val(ir_op), .out_onehot(op_onehot));

  assign t_act            = s_q ? t_raw : '0;
  assign fetch_decode_end = !r_q && t_act[T2_IDX];

  always_comb begin
    s_d   = s_q;
    sc_d  = sc_q + 1'b1;
    r_d   = r_q;
    d_d   = d_q;
    i_d   = i_q;
    ovr_d = ovr_q;

    if (halt_req && s_q)
      s_d = 1'b0;
    else if (start && !s_q)
      s_d = 1'b1;

    // Interrupt cycle ends on its own at RT2, regardless of sc_clr.
    if (!s_q || halt_req)
      sc_d = '0;
    else if (sc_clr)
      sc_d = '0;
    else if (r_q && t_act[T2_IDX])
      sc_d = '0;
    else if (sc_q == SC_MAX) begin
      sc_d  = '0;
      ovr_d = 1'b1;
    end

    if (s_q && !r_q && !(t_act[T0_IDX] | t_act[T1_IDX] | t_act[T2_IDX])
        && ien && (fgi | fgo))
      r_d = 1'b1;
    else if (r_q && t_act[T2_IDX])
      r_d = 1'b0;

    if (fetch_decode_end) begin
      d_d = op_onehot;
      i_d = ir_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= 1'b0;
      sc_q  <= '0;
      r_q   <= 1'b0;
      d_q   <= '0;
      i_q   <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      sc_q  <= sc_d;
      r_q   <= r_d;
      d_q   <= d_d;
      i_q   <= i_d;
      ovr_q <= ovr_d;
    end
  end

  assign running    = s_q;
  assign T          = t_act;
  assign D          = d_q;
  assign I          = i_q;
  assign R          = r_q;
  assign sc_overrun = ovr_q;

  assign ar_ld_pc  = !r_q && t_act[T0_IDX];
  assign ir_ld_mem = !r_q && t_act[T1_IDX];
  assign pc_inc    = (!r_q && t_act[T1_IDX]) || (r_q && t_act[T2_IDX]);
  assign ar_ld_ir  = !r_q && t_act[T2_IDX];
  assign ar_clr    = r_q && t_act[T0_IDX];
  assign tr_ld_pc  = r_q && t_act[T0_IDX];
  assign mem_wr_tr = r_q && t_act[T1_IDX];
  assign pc_clr    = r_q && t_act[T1_IDX];
  assign ien_clr   = r_q && t_act[T2_IDX];

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer: directed vector table, corner sequences and a random run against a rule model.
module tb_timing_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start, halt_req, sc_clr, ir_i, ien, fgi, fgo;
  logic [2:0]  ir_op;
  logic        running, I, R, sc_overrun;
  logic [15:0] T;
  logic [7:0]  D;
  logic        ar_ld_pc, ir_ld_mem, pc_inc, ar_ld_ir, ar_clr, tr_ld_pc;
  logic        mem_wr_tr, pc_clr, ien_clr;

  int checks = 0;
  int errors = 0;

  // Strobe vector order: ar_ld_pc ir_ld_mem pc_inc ar_ld_ir ar_clr tr_ld_pc mem_wr_tr pc_clr ien_clr
  localparam logic [8:0] S_NONE = 9'b000000000;
  localparam logic [8:0] S_F0   = 9'b100000000;
  localparam logic [8:0] S_F1   = 9'b011000000;
  localparam logic [8:0] S_F2   = 9'b000100000;
  localparam logic [8:0] S_I0   = 9'b000011000;
  localparam logic [8:0] S_I1   = 9'b000000110;
  localparam logic [8:0] S_I2   = 9'b001000001;

  timing_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req), .sc_clr(sc_clr),
    .ir_op(ir_op), .ir_i(ir_i), .ien(ien), .fgi(fgi), .fgo(fgo),
    .running(running), .T(T), .D(D), .I(I), .R(R),
    .ar_ld_pc(ar_ld_pc), .ir_ld_mem(ir_ld_mem), .pc_inc(pc_inc), .ar_ld_ir(ar_ld_ir),
    .ar_clr(ar_clr), .tr_ld_pc(tr_ld_pc), .mem_wr_tr(mem_wr_tr), .pc_clr(pc_clr),
    .ien_clr(ien_clr), .sc_overrun(sc_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, hr, sc, ie, fi, fo;
    logic [2:0] op;
    logic       ii;
    logic       e_run;
    logic [15:0] e_t;
    logic       e_r;
    logic [7:0] e_d;
    logic       e_i;
    logic [8:0] e_strb;
    logic       e_ov;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic st, hr, sc, ie, fi, input logic [2:0] op,
                              input logic ii, e_run, input logic [15:0] e_t,
                              input logic e_r, input logic [7:0] e_d, input logic e_i,
                              input logic [8:0] e_strb);
    vec_t v;
    v.st = st; v.hr = hr; v.sc = sc; v.ie = ie; v.fi = fi; v.fo = 1'b0;
    v.op = op; v.ii = ii; v.e_run = e_run; v.e_t = e_t; v.e_r = e_r;
    v.e_d = e_d; v.e_i = e_i; v.e_strb = e_strb; v.e_ov = 1'b0;
    return v;
  endfunction

  function automatic logic [8:0] strobes();
    return {ar_ld_pc, ir_ld_mem, pc_inc, ar_ld_ir, ar_clr, tr_ld_pc, mem_wr_tr, pc_clr, ien_clr};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, hr, sc, ie, fi, fo, input logic [2:0] op, input logic ii);
    start = st; halt_req = hr; sc_clr = sc; ien = ie; fgi = fi; fgo = fo;
    ir_op = op; ir_i = ii;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 3'd0, 0);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Rule-level reference model used by the random phase
  bit          m_s, m_r, m_i, m_ov;
  int          m_sc;
  logic [7:0]  m_d;

  function automatic logic [8:0] model_strobes();
    if (!m_s) return S_NONE;
    case (m_sc)
      0: return m_r ? S_I0 : S_F0;
      1: return m_r ? S_I1 : S_F1;
      2: return m_r ? S_I2 : S_F2;
      default: return S_NONE;
    endcase
  endfunction

  task automatic model_step(input bit st, hr, sc, ie, fi, fo, input int op, input bit ii);
    bit  n_s, n_r;
    int  n_sc;
    n_s = m_s;
    if (hr && m_s) n_s = 0;
    else if (st && !m_s) n_s = 1;
    n_r = m_r;
    if (m_s && !m_r && m_sc > 2 && ie && (fi || fo)) n_r = 1;
    else if (m_s && m_r && m_sc == 2) n_r = 0;
    if (m_s && !m_r && m_sc == 2) begin
      m_d = 8'(1 << op);
      m_i = ii;
    end
    if (!m_s || hr || sc || (m_r && m_sc == 2)) n_sc = 0;
    else if (m_sc == 15) begin
      n_sc = 0;
      m_ov = 1;
    end else n_sc = m_sc + 1;
    m_s = n_s; m_r = n_r; m_sc = n_sc;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 3'd0, 0);
    #12;
    chk("reset_running", 32'(running), 0);
    chk("reset_T", 32'(T), 0);
    chk("reset_R_D_I_ov", {28'd0, R, I, sc_overrun, |D}, 0);
    chk("reset_strobes", 32'(strobes()), 0);
    rst_n = 1'b1;
    @(negedge clk);

    //              st hr sc ie fi op    ii run T        R  D      I  strobes
    vecs[0]  = mk(1, 0, 0, 0, 0, 3'd2, 1, 1, 16'h0001, 0, 8'h00, 0, S_F0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 3'd2, 1, 1, 16'h0002, 0, 8'h00, 0, S_F1);
    vecs[2]  = mk(0, 0, 0, 0, 0, 3'd2, 1, 1, 16'h0004, 0, 8'h00, 0, S_F2);
    vecs[3]  = mk(0, 0, 0, 0, 0, 3'd2, 1, 1, 16'h0008, 0, 8'h04, 1, S_NONE);
    vecs[4]  = mk(0, 0, 0, 0, 0, 3'd2, 1, 1, 16'h0010, 0, 8'h04, 1, S_NONE);
    vecs[5]  = mk(0, 0, 1, 0, 0, 3'd2, 1, 1, 16'h0001, 0, 8'h04, 1, S_F0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 3'd2, 1, 1, 16'h0002, 0, 8'h04, 1, S_F1);
    vecs[7]  = mk(0, 0, 0, 0, 0, 3'd2, 1, 1, 16'h0004, 0, 8'h04, 1, S_F2);
    vecs[8]  = mk(0, 0, 0, 0, 0, 3'd5, 0, 1, 16'h0008, 0, 8'h20, 0, S_NONE);
    vecs[9]  = mk(0, 0, 0, 1, 1, 3'd5, 0, 1, 16'h0010, 1, 8'h20, 0, S_NONE);
    vecs[10] = mk(0, 0, 1, 1, 1, 3'd5, 0, 1, 16'h0001, 1, 8'h20, 0, S_I0);
    vecs[11] = mk(0, 0, 0, 1, 1, 3'd5, 0, 1, 16'h0002, 1, 8'h20, 0, S_I1);
    vecs[12] = mk(0, 0, 0, 1, 1, 3'd5, 0, 1, 16'h0004, 1, 8'h20, 0, S_I2);
    vecs[13] = mk(0, 0, 0, 0, 0, 3'd7, 1, 1, 16'h0001, 0, 8'h20, 0, S_F0);
    vecs[14] = mk(0, 0, 0, 0, 0, 3'd7, 1, 1, 16'h0002, 0, 8'h20, 0, S_F1);
    vecs[15] = mk(0, 0, 0, 0, 0, 3'd7, 1, 1, 16'h0004, 0, 8'h20, 0, S_F2);
    vecs[16] = mk(0, 0, 0, 0, 0, 3'd7, 1, 1, 16'h0008, 0, 8'h80, 1, S_NONE);
    vecs[17] = mk(0, 0, 0, 0, 0, 3'd7, 1, 1, 16'h0010, 0, 8'h80, 1, S_NONE);
    vecs[18] = mk(0, 0, 0, 0, 0, 3'd7, 1, 1, 16'h0020, 0, 8'h80, 1, S_NONE);
    vecs[19] = mk(0, 1, 0, 0, 0, 3'd3, 0, 0, 16'h0000, 0, 8'h80, 1, S_NONE);
    vecs[20] = mk(1, 0, 0, 0, 0, 3'd3, 0, 1, 16'h0001, 0, 8'h80, 1, S_F0);
    vecs[21] = mk(1, 0, 0, 0, 0, 3'd3, 0, 1, 16'h0002, 0, 8'h80, 1, S_F1);
    vecs[22] = mk(1, 0, 0, 0, 0, 3'd3, 0, 1, 16'h0004, 0, 8'h80, 1, S_F2);
    vecs[23] = mk(0, 0, 0, 0, 0, 3'd3, 0, 1, 16'h0008, 0, 8'h08, 0, S_NONE);
    vecs[24] = mk(0, 1, 1, 0, 0, 3'd3, 0, 0, 16'h0000, 0, 8'h08, 0, S_NONE);
    vecs[25] = mk(0, 0, 1, 0, 0, 3'd3, 0, 0, 16'h0000, 0, 8'h08, 0, S_NONE);

    for (int k = 0; k < 26; k++) begin
      drive(vecs[k].st, vecs[k].hr, vecs[k].sc, vecs[k].ie, vecs[k].fi, vecs[k].fo,
            vecs[k].op, vecs[k].ii);
      tick();
      chk($sformatf("vec%0d_running", k), 32'(running), 32'(vecs[k].e_run));
      chk($sformatf("vec%0d_T", k), 32'(T), 32'(vecs[k].e_t));
      chk($sformatf("vec%0d_R", k), 32'(R), 32'(vecs[k].e_r));
      chk($sformatf("vec%0d_D", k), 32'(D), 32'(vecs[k].e_d));
      chk($sformatf("vec%0d_I", k), 32'(I), 32'(vecs[k].e_i));
      chk($sformatf("vec%0d_strobes", k), 32'(strobes()), 32'(vecs[k].e_strb));
      chk($sformatf("vec%0d_overrun", k), 32'(sc_overrun), 32'(vecs[k].e_ov));
      $display("vec %0d: T=%h R=%0b D=%h I=%0b run=%0b", k, T, R, D, I, running);
    end

    // Asynchronous reset in the middle of an instruction at T5
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 3'd6, 1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3'd6, 1);
    repeat (5) tick();
    chk("pre_async_T5", 32'(T), 32'h0020);
    chk("pre_async_D", 32'(D), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    chk("async_running", 32'(running), 0);
    chk("async_T", 32'(T), 0);
    chk("async_R", 32'(R), 0);
    chk("async_D", 32'(D), 0);
    chk("async_I", 32'(I), 0);
    $display("async reset: run=%0b T=%h D=%h", running, T, D);
    @(negedge clk);
    rst_n = 1'b1;

    // Overrun: SC walks all 16 states, wraps, and the flag sticks until reset
    drive(1, 0, 0, 0, 0, 0, 3'd0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3'd0, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("walk_T%0d", k), 32'(T), 32'(16'h1 << k));
      chk($sformatf("walk_ov%0d", k), 32'(sc_overrun), 0);
      tick();
    end
    chk("wrap_T", 32'(T), 32'h0001);
    chk("wrap_ov", 32'(sc_overrun), 1);
    drive(0, 1, 0, 0, 0, 0, 3'd0, 0);
    tick();
    chk("ov_after_halt", 32'(sc_overrun), 1);
    drive(1, 0, 0, 0, 0, 0, 3'd0, 0);
    tick();
    chk("ov_after_restart", 32'(sc_overrun), 1);
    chk("restart_T", 32'(T), 32'h0001);
    $display("overrun: ov=%0b T=%h", sc_overrun, T);
    do_reset();
    chk("ov_cleared_by_reset", 32'(sc_overrun), 0);

    // Random stimulus against the rule model
    m_s = 0; m_r = 0; m_i = 0; m_ov = 0; m_sc = 0; m_d = 8'h00;
    for (int n = 0; n < 600; n++) begin
      bit st, hr, sc, ie, fi, fo, ii;
      int op;
      logic [15:0] e_t;
      st = ($urandom_range(0, 3) == 0);
      hr = ($urandom_range(0, 19) == 0);
      sc = ($urandom_range(0, 6) == 0);
      ie = ($urandom_range(0, 1) == 0);
      fi = ($urandom_range(0, 3) == 0);
      fo = ($urandom_range(0, 3) == 0);
      ii = ($urandom_range(0, 1) == 0);
      op = int'($urandom_range(0, 7));
      drive(st, hr, sc, ie, fi, fo, 3'(op), ii);
      model_step(st, hr, sc, ie, fi, fo, op, ii);
      tick();
      e_t = m_s ? (16'h1 << m_sc) : 16'h0;
      chk($sformatf("rnd%0d_T", n), 32'(T), 32'(e_t));
      chk($sformatf("rnd%0d_state", n), {27'd0, running, R, I, sc_overrun, 1'b0},
          {27'd0, m_s, m_r, m_i, m_ov, 1'b0});
      chk($sformatf("rnd%0d_D", n), 32'(D), 32'(m_d));
      chk($sformatf("rnd%0d_strobes", n), 32'(strobes()), 32'(model_strobes()));
      $display("rnd %0d: st=%0b hr=%0b sc=%0b ie=%0b T=%h R=%0b D=%h", n, st, hr, sc, ie, T, R, D);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
